// File: rtl/carrier_freq_meas.sv
// Carrier frequency meter: gates GATE_PERIODS hysteretic rising zero-crossings, then divides
// 2^(12+GATE_LOG2) by the gate length to recover the generator's 12-bit phase-step word.
module carrier_freq_meas #(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            GATE_LOG2  = 4,
  parameter logic signed [DATA_WIDTH-1:0]  HYST       = 32'sd1048576,
  parameter int                            CNT_WIDTH  = 16,
  parameter int                            STEP_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic signed [DATA_WIDTH-1:0]  sample_in,
  output logic [STEP_WIDTH-1:0]         step_est,
  output logic                          step_valid,
  output logic                          no_signal,
  output logic                          busy
);

  localparam int NUM_W        = 13 + GATE_LOG2;
  localparam int BIT_W        = $clog2(NUM_W);
  localparam int GATE_PERIODS = 1 << GATE_LOG2;

  localparam logic signed [DATA_WIDTH-1:0] HYST_NEG = -HYST;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [NUM_W-1:0]      NUM_BASE  = NUM_W'(1 << (12 + GATE_LOG2));
  localparam logic [NUM_W-1:0]      STEP_MAX  = NUM_W'((1 << STEP_WIDTH) - 1);
  localparam logic [GATE_LOG2-1:0]  LAST_PER  = GATE_LOG2'(GATE_PERIODS - 1);
  localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(NUM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GATE,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic                   arm;
  logic                   arm_nx;
  logic                   ev;
  logic                   timeout;
  logic                   close_ev;
  logic [CNT_WIDTH-1:0]   counter;
  logic [GATE_LOG2-1:0]   periods;
  logic [CNT_WIDTH-1:0]   divisor;
  logic [NUM_W-1:0]       num;
  logic [CNT_WIDTH-1:0]   rem;
  logic [BIT_W-1:0]       bit_cnt;
  logic [CNT_WIDTH:0]     rem_sh;
  logic [CNT_WIDTH-1:0]   rem_nx;
  logic                   q_bit;

  // Arm below -HYST, fire at or above +HYST: noise inside the band cannot retrigger.
  always_comb begin
    ev     = arm && (sample_in >= HYST);
    arm_nx = arm;
    if (state == S_IDLE && !en) begin
      arm_nx = 1'b0;
    end else if (sample_in < HYST_NEG) begin
      arm_nx = 1'b1;
    end else if (ev) begin
      arm_nx = 1'b0;
    end
  end

  assign timeout  = (counter == CNT_MAX);
  assign close_ev = ev && (periods == LAST_PER);

  // One restoring step: shift the next numerator bit into the remainder, subtract if it fits.
  always_comb begin
    rem_sh = {rem, num[NUM_W-1]};
    q_bit  = 1'b0;
    rem_nx = rem_sh[CNT_WIDTH-1:0];
    if (rem_sh >= {1'b0, divisor}) begin
      q_bit  = 1'b1;
      rem_nx = CNT_WIDTH'(rem_sh - {1'b0, divisor});
    end
  end

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nx = S_WAIT;
        S_WAIT:   if (ev) state_nx = S_GATE;
        S_GATE: begin
          if (close_ev)     state_nx = S_DIVIDE;
          else if (timeout) state_nx = S_WAIT;
        end
        S_DIVIDE: if (bit_cnt == LAST_BIT) state_nx = S_DONE;
        S_DONE:   state_nx = S_WAIT;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // step_valid is a single-cycle strobe with no back-pressure: step_est is valid in the
  // cycle step_valid is high and holds until the next strobe or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm        <= 1'b0;
      counter    <= '0;
      periods    <= '0;
      divisor    <= '0;
      num        <= '0;
      rem        <= '0;
      bit_cnt    <= '0;
      step_est   <= '0;
      step_valid <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      arm        <= arm_nx;
      step_valid <= 1'b0;
      if (!en) begin
        counter <= '0;
        periods <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: counter <= '0;
          S_WAIT: begin
            if (ev) begin
              counter <= CNT_WIDTH'(1);
              periods <= '0;
            end else if (timeout) begin
              counter   <= '0;
              no_signal <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
          S_GATE: begin
            if (close_ev) begin
              divisor <= counter;
              num     <= NUM_BASE + NUM_W'(counter >> 1);
              rem     <= '0;
              bit_cnt <= '0;
            end else if (timeout) begin
              counter   <= '0;
              no_signal <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
              if (ev) periods <= periods + 1'b1;
            end
          end
          S_DIVIDE: begin
            num     <= {num[NUM_W-2:0], q_bit};
            rem     <= rem_nx;
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_DONE: begin
            step_est   <= (num > STEP_MAX) ? STEP_MAX[STEP_WIDTH-1:0] : num[STEP_WIDTH-1:0];
            step_valid <= 1'b1;
            no_signal  <= 1'b0;
            counter    <= '0;
          end
          default: counter <= '0;
        endcase
      end
    end
  end

  assign busy = (state == S_GATE) || (state == S_DIVIDE);

endmodule

// File: tb/tb_carrier_freq_meas.sv
// Self-checking bench for carrier_freq_meas: sine stimulus from a generator-style phase
// accumulator, checked against an event-list reference model of the measurement rules.
module tb_carrier_freq_meas;

  localparam int HYST    = 1048576;
  localparam int LAT     = 19;
  localparam int NEVER   = 32'h7fffffff;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic signed [31:0] sample_in = '0;
  logic [9:0]         step_est;
  logic               step_valid;
  logic               no_signal;
  logic               busy;

  carrier_freq_meas dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sample_in  (sample_in),
    .step_est   (step_est),
    .step_valid (step_valid),
    .no_signal  (no_signal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  en_req = 1'b0;
  int  n_pulses = 0;
  int  nominal = -1;
  logic [9:0] last_est = '0;

  // Carrier generator: 12-bit phase accumulator into a sine of amplitude 2^30
  int  phase = 0;
  int  step = 0;
  bit  tone_on = 1'b0;
  int  noise_amp = 0;
  real amp = 1073741824.0;

  // Reference model state
  bit  m_arm = 1'b0;
  bit  m_prev_en = 1'b0;
  bit  m_open = 1'b0;
  int  m_open_t = 0;
  int  m_nev = 0;
  int  m_ready = NEVER;
  int  m_div_end = 0;
  logic [9:0] exp_q[$];
  int         exp_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [9:0] ref_step(input int count);
    int q;
    q = (65536 + count / 2) / count;
    return (q > 1023) ? 10'd1023 : 10'(q);
  endfunction

  function automatic int gen();
    int s;
    s = 0;
    if (tone_on) s = $rtoi(amp * $sin(6.283185307179586 * real'(phase) / 4096.0));
    if (noise_amp > 0) s = s + int'($urandom_range(2 * noise_amp)) - noise_amp;
    phase = (phase + step) % 4096;
    return s;
  endfunction

  // Measurement rules expressed over the stream of crossing events
  task automatic model_step(input int s, input bit e);
    bit idle;
    bit ev;
    int cnt;
    idle = !m_prev_en;
    ev = 1'b0;
    if (idle && !e) begin
      m_arm = 1'b0;
    end else begin
      ev = m_arm && (s >= HYST);
      if (s < -HYST) m_arm = 1'b1;
      else if (ev) m_arm = 1'b0;
    end
    if (!e) begin
      if (m_open && cyc > m_open_t) m_div_end = cyc;
      else if (m_div_end > cyc) m_div_end = cyc;
      m_open = 1'b0;
      m_ready = NEVER;
      while (exp_t.size() > 0 && exp_t[$] > cyc) begin
        void'(exp_t.pop_back());
        void'(exp_q.pop_back());
      end
    end else if (idle) begin
      m_ready = cyc + 1;
    end else if (ev) begin
      if (m_open) begin
        m_nev++;
        if (m_nev == 16) begin
          cnt = cyc - m_open_t;
          exp_t.push_back(cyc + LAT);
          exp_q.push_back(ref_step(cnt));
          m_div_end = cyc + LAT - 2;
          m_ready = cyc + LAT;
          m_open = 1'b0;
        end
      end else if (cyc >= m_ready) begin
        m_open = 1'b1;
        m_open_t = cyc;
        m_nev = 0;
      end
    end
    m_prev_en = e;
  endtask

  task automatic cycle();
    int s;
    bit exp_valid;
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", busy, ((m_open && cyc > m_open_t) || cyc <= m_div_end));
    while (exp_t.size() > 0 && exp_t[0] < cyc) begin
      void'(exp_t.pop_front());
      void'(exp_q.pop_front());
    end
    exp_valid = (exp_t.size() > 0) && (exp_t[0] == cyc);
    chk("step_valid", step_valid, exp_valid);
    if (step_valid) n_pulses++;
    if (exp_valid) begin
      chk("step_est", step_est, exp_q[0]);
      chk("no_signal_clear", no_signal, 0);
      if (nominal >= 0) chk("step_nominal", step_est, nominal);
      else if (nominal == -2) chk("step_range", (step_est >= 10'd1000), 1);
      last_est = exp_q[0];
      void'(exp_t.pop_front());
      void'(exp_q.pop_front());
    end
    s = gen();
    en = en_req;
    sample_in = s;
    model_step(s, en_req);
  endtask

  task automatic run_meas(input string tag, input int n, input int budget);
    int start;
    int k;
    start = n_pulses;
    k = 0;
    while (n_pulses - start < n && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, n_pulses - start, n);
  endtask

  task automatic start_tone(input int stp, input int noise, input int nom);
    step = stp;
    phase = $urandom_range(4095);
    tone_on = 1'b1;
    noise_amp = noise;
    nominal = nom;
  endtask

  task automatic do_reset();
    int s;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_step_est", step_est, 0);
    chk("rst_step_valid", step_valid, 0);
    chk("rst_no_signal", no_signal, 0);
    chk("rst_busy", busy, 0);
    m_arm = 1'b0;
    m_prev_en = 1'b0;
    m_open = 1'b0;
    m_div_end = 0;
    m_ready = NEVER;
    exp_q.delete();
    exp_t.delete();
    last_est = '0;
    en_req = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    s = gen();
    sample_in = s;
    model_step(s, 1'b0);
  endtask

  task automatic wait_open();
    int k;
    k = 0;
    while (!m_open && k < 600) begin
      cycle();
      k++;
    end
  endtask

  task automatic wait_close();
    int k;
    k = 0;
    while (m_div_end <= cyc && k < 1500) begin
      cycle();
      k++;
    end
  endtask

  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_step_est", step_est, 0);
    chk("reset_step_valid", step_valid, 0);
    chk("reset_no_signal", no_signal, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // Step 64 carrier: count 1024, estimate 64
    start_tone(64, 0, 64);
    en_req = 1'b1;
    run_meas("meas_step64", 2, 3000);
    en_req = 1'b0;
    repeat (4) cycle();
    chk("hold_after_en_drop", step_est, last_est);

    // Step 100 carrier: non-integer period
    start_tone(100, 0, 100);
    en_req = 1'b1;
    run_meas("meas_step100", 2, 3000);

    // Near the top of the range, then exact saturation at count 64
    start_tone(1023, 0, -2);
    run_meas("meas_step1023", 3, 800);
    start_tone(1024, 0, 1023);
    run_meas("meas_step1024_sat", 2, 500);

    // Constant input: timeout sets sticky no_signal, never a result
    en_req = 1'b0;
    repeat (2) cycle();
    tone_on = 1'b0;
    noise_amp = 0;
    en_req = 1'b1;
    e0 = n_pulses;
    repeat (65500) cycle();
    chk("no_signal_before_timeout", no_signal, 0);
    repeat (60) cycle();
    chk("no_signal_after_timeout", no_signal, 1);
    chk("no_pulse_on_silence", n_pulses - e0, 0);
    start_tone(64, 0, 64);
    repeat (20) cycle();
    chk("no_signal_sticky", no_signal, 1);
    run_meas("meas_after_timeout", 1, 2000);
    chk("no_signal_cleared", no_signal, 0);

    // Noise inside the hysteresis band must not add events
    start_tone(64, HYST / 2, 64);
    run_meas("meas_noisy", 2, 3000);

    // en drop mid-GATE
    wait_open();
    repeat ($urandom_range(800, 50)) cycle();
    chk("busy_mid_gate", busy, 1);
    en_req = 1'b0;
    repeat (3) cycle();
    chk("hold_est_gate_drop", step_est, last_est);
    en_req = 1'b1;
    run_meas("meas_after_gate_drop", 1, 2500);

    // en drop mid-DIVIDE
    wait_close();
    repeat ($urandom_range(14, 1)) cycle();
    chk("busy_mid_divide", busy, 1);
    en_req = 1'b0;
    repeat (25) cycle();
    chk("hold_est_div_drop", step_est, last_est);
    en_req = 1'b1;
    run_meas("meas_after_div_drop", 1, 2500);

    // Reset mid-GATE and mid-DIVIDE
    start_tone(100, HYST / 2, 100);
    wait_open();
    repeat ($urandom_range(500, 20)) cycle();
    do_reset();
    en_req = 1'b1;
    run_meas("meas_after_gate_reset", 1, 2500);
    wait_close();
    repeat ($urandom_range(14, 1)) cycle();
    do_reset();
    repeat (25) cycle();
    chk("est_zero_after_reset", step_est, 0);
    en_req = 1'b1;
    run_meas("meas_after_div_reset", 1, 2500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/carrier_freq_meas.md
Name: carrier_freq_meas

Overview:
- Receive-side counterpart of the I/Q carrier generator: takes a sampled carrier and recovers the phase-step word that would produce it.
- The step word uses the same 12-bit phase / 4096-entry LUT convention as the generator, so the result feeds straight back into the generator's step domain.
- Used by the demodulator for carrier frequency acquisition and as a self-check when looped back from the modulator.
- Method: count clock cycles over GATE_PERIODS carrier periods (hysteretic rising zero-crossings), then run a sequential restoring divide.

Parameters:
- DATA_WIDTH, 32, width of signed input sample.
- GATE_LOG2, 4, log2 of the number of carrier periods per measurement (GATE_PERIODS = 16).
- HYST, 32'sd1048576, hysteresis threshold magnitude for zero-crossing detection.
- CNT_WIDTH, 16, width of the period cycle counter.
- STEP_WIDTH, 10, width of the output step estimate.

Ports:
- clk  input  1  sample clock, same clock as the carrier generator (230,401.25 Hz).
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  measurement enable; low forces IDLE.
- sample_in  input  DATA_WIDTH  signed carrier sample, one per clock.
- step_est  output  STEP_WIDTH  last completed step estimate.
- step_valid  output  1  one-cycle pulse when step_est updates.
- no_signal  output  1  sticky until the next valid result; counter timed out.
- busy  output  1  high in GATE or DIVIDE.

Behaviour:
- Reset is asynchronous, active-low, and applies to all state and outputs:
  - step_est = 0, step_valid = 0, no_signal = 0, busy = 0.
  - State = IDLE, arm = 0, counter = 0.
- Crossing detector:
  - arm sets when sample_in < -HYST.
  - Event fires in a cycle where arm = 1 and sample_in >= HYST; arm clears in that same cycle.
  - Samples between -HYST and HYST change nothing.
  - The detector runs in all states except IDLE with en = 0, where arm is held at 0.
- State machine:
  - IDLE → WAIT when en = 1.
  - WAIT → GATE on the first event: counter is loaded with 1 and the period counter with 0.
  - GATE: counter increments every clock. Each event increments the period counter.
  - GATE → DIVIDE on the event that brings the period counter to GATE_PERIODS. On that event, count = counter value (clocks from the opening event to the closing event) is latched.
  - Timeout: if the counter reaches 2^CNT_WIDTH − 1 in GATE or WAIT, set no_signal = 1 and go to WAIT with the counter cleared. The WAIT count starts on entry.
  - DIVIDE: numerator N = 2^(12+GATE_LOG2) + (count >> 1), for rounding. Restoring division produces one quotient bit per clock, giving NUM_W = 13 + GATE_LOG2 cycles.
  - DONE (one cycle): step_est = quotient, saturated to 2^STEP_WIDTH − 1; step_valid = 1; no_signal = 0. Then → WAIT.
  - The closing event is not reused; the next measurement opens on the next event.
- Latency: step_valid asserts exactly NUM_W + 2 clocks after the clock in which the closing-event sample is presented.
- busy = 1 in GATE and DIVIDE.
- en deasserted in any state → IDLE on the next clock. Any in-progress measurement or divide is discarded, and step_est and no_signal are retained.
- sample_in changes during DIVIDE are ignored apart from arm tracking.
- Arithmetic: the divider is unsigned. count is never 0 in DIVIDE, because the minimum is GATE_PERIODS × 2 given hysteresis.

Test Plan:
- Step 64 sine from the generator (period 64 clocks), en = 1 → count = 1024, step_est = 64, step_valid pulses once per measurement, busy high during GATE and DIVIDE.
- Step 100 sine (period ≈ 40.96 clocks) → count 655 or 656, step_est = 100 ± 0.
- Step 1023 sine (period ≈ 4 clocks) → step_est between 1000 and 1023, no overflow; force count = 64 via model → step_est saturates to 1023.
- Constant 0 input → after 65535 clocks no_signal = 1 and step_valid never pulses; then apply the step-64 sine → step_est = 64 and no_signal clears on step_valid.
- Noisy step-64 sine with ±HYST/2 noise near zero → step_est = 64, no double-counted events.
- Reset or en deassert mid-GATE and mid-DIVIDE → no step_valid, return to IDLE, previous step_est retained on en drop, step_est = 0 after reset; the next full measurement is correct.
